hx8352_bus_writer: RTL and testbench

Physical-layer stage directly downstream of `hx8352_controller_fsm`. It consumes that block's `bus_step`/`command_or_data`/`data_to_write` write requests and `delay_step`/`delay_value` delay requests. Write requests become timed 16-bit 8080-style write cycles on the HX8352 pins (RS, WR#, RD#, DB). Delay requests become microsecond waits. Completion is reported with `bus_done` and `delay_done` pulses.

---
 rtl/hx8352_pkg.sv | 27 ++
 rtl/hx8352_bus_writer_us_tick.sv | 29 ++
 rtl/hx8352_bus_writer.sv | 154 +++++++++++++++
 tb/tb_hx8352_bus_writer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/hx8352_pkg.sv
// Shared definitions for the HX8352 bus writer: pin encodings, FSM states, default timing.
// No logic; latency and backpressure are defined by the modules that import it.
package hx8352_pkg;

    localparam logic LCD_CMD  = 1'b0;
    localparam logic LCD_DATA = 1'b1;

    localparam int DEF_CLKS_PER_US = 50;
    localparam int DEF_SETUP_CYC   = 1;
    localparam int DEF_WR_LOW_CYC  = 3;
    localparam int DEF_WR_HIGH_CYC = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_WR_LOW,
        ST_WR_HIGH,
        ST_DELAY
    } bw_state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/hx8352_bus_writer_us_tick.sv
// Microsecond prescaler: tick is high for one cycle every CLKS_PER_US cycles.
// Tick follows the registered count combinationally; clear restarts the period, no backpressure.
module hx8352_us_tick #(
    parameter int CLKS_PER_US = 50
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_US - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/hx8352_bus_writer.sv
// 8080-style 16-bit write cycles and microsecond waits for the HX8352; SETUP+WR_LOW+WR_HIGH cycles per write.
// No queuing: requests arriving while busy (or a delay colliding with a write) are dropped and flagged.
module hx8352_bus_writer
    import hx8352_pkg::*;
#(
    parameter int CLKS_PER_US = DEF_CLKS_PER_US,
    parameter int SETUP_CYC   = DEF_SETUP_CYC,
    parameter int WR_LOW_CYC  = DEF_WR_LOW_CYC,
    parameter int WR_HIGH_CYC = DEF_WR_HIGH_CYC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bus_step,
    input  logic        command_or_data,
    input  logic [15:0] data_to_write,
    input  logic        delay_step,
    input  logic [15:0] delay_value,
    output logic        busy,
    output logic        bus_done,
    output logic        delay_done,
    output logic        req_dropped,
    output logic        lcd_rs,
    output logic        lcd_wr_n,
    output logic        lcd_rd_n,
    output logic [15:0] lcd_db
);

    localparam int PH_MAX = max3(SETUP_CYC, WR_LOW_CYC, WR_HIGH_CYC);
    localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

    bw_state_t   state, state_nxt;
    logic [PH_W-1:0] ph_cnt, ph_nxt;
    logic [15:0] us_cnt, us_nxt;
    logic [15:0] db_nxt;
    logic        rs_nxt, wr_n_nxt, busy_nxt, bus_done_nxt, delay_done_nxt, drop_nxt;
    logic        presc_clear, us_tick;

    hx8352_us_tick #(
        .CLKS_PER_US(CLKS_PER_US)
    ) u_us_tick (
        .clk  (clk),
        .rst  (rst),
        .clear(presc_clear),
        .tick (us_tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            ph_cnt      <= '0;
            us_cnt      <= '0;
            lcd_db      <= '0;
            lcd_rs      <= LCD_CMD;
            lcd_wr_n    <= 1'b1;
            lcd_rd_n    <= 1'b1;
            busy        <= 1'b0;
            bus_done    <= 1'b0;
            delay_done  <= 1'b0;
            req_dropped <= 1'b0;
        end else begin
            state       <= state_nxt;
            ph_cnt      <= ph_nxt;
            us_cnt      <= us_nxt;
            lcd_db      <= db_nxt;
            lcd_rs      <= rs_nxt;
            lcd_wr_n    <= wr_n_nxt;
            lcd_rd_n    <= 1'b1;
            busy        <= busy_nxt;
            bus_done    <= bus_done_nxt;
            delay_done  <= delay_done_nxt;
            req_dropped <= drop_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        ph_nxt         = ph_cnt;
        us_nxt         = us_cnt;
        db_nxt         = lcd_db;
        rs_nxt         = lcd_rs;
        wr_n_nxt       = 1'b1;
        busy_nxt       = busy;
        bus_done_nxt   = 1'b0;
        delay_done_nxt = 1'b0;
        drop_nxt       = req_dropped;
        presc_clear    = 1'b0;

        case (state)
            ST_IDLE: begin
                if (bus_step) begin
                    state_nxt = ST_SETUP;
                    ph_nxt    = PH_W'(SETUP_CYC - 1);
                    db_nxt    = data_to_write;
                    rs_nxt    = command_or_data;
                    busy_nxt  = 1'b1;
                    if (delay_step) begin
                        drop_nxt = 1'b1;
                    end
                end else if (delay_step) begin
                    state_nxt   = ST_DELAY;
                    us_nxt      = delay_value;
                    busy_nxt    = 1'b1;
                    presc_clear = 1'b1;
                end
            end
            ST_SETUP: begin
                if (ph_cnt == '0) begin
                    state_nxt = ST_WR_LOW;
                    ph_nxt    = PH_W'(WR_LOW_CYC - 1);
                    wr_n_nxt  = 1'b0;
                end else begin
                    ph_nxt = ph_cnt - PH_W'(1);
                end
            end
            ST_WR_LOW: begin
                if (ph_cnt == '0) begin
                    state_nxt = ST_WR_HIGH;
                    ph_nxt    = PH_W'(WR_HIGH_CYC - 1);
                end else begin
                    ph_nxt   = ph_cnt - PH_W'(1);
                    wr_n_nxt = 1'b0;
                end
            end
            ST_WR_HIGH: begin
                if (ph_cnt == '0) begin
                    state_nxt    = ST_IDLE;
                    busy_nxt     = 1'b0;
                    bus_done_nxt = 1'b1;
                end else begin
                    ph_nxt = ph_cnt - PH_W'(1);
                end
            end
            ST_DELAY: begin
                // A zero-length delay finishes on the first cycle in DELAY.
                if (us_cnt == '0 || (us_tick && us_cnt == 16'd1)) begin
                    state_nxt      = ST_IDLE;
                    busy_nxt       = 1'b0;
                    delay_done_nxt = 1'b1;
                end else if (us_tick) begin
                    us_nxt = us_cnt - 16'd1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                busy_nxt  = 1'b0;
            end
        endcase

        if (state != ST_IDLE && (bus_step || delay_step)) begin
            drop_nxt = 1'b1;
        end
    end

endmodule

// File: tb/tb_hx8352_bus_writer.sv
// Scoreboarded bench for hx8352_bus_writer: directed writes, delays, collisions, reset and a 50-step init script.
module tb_hx8352_bus_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic        bus_step;
    logic        command_or_data;
    logic [15:0] data_to_write;
    logic        delay_step;
    logic [15:0] delay_value;
    logic        busy, bus_done, delay_done, req_dropped;
    logic        lcd_rs, lcd_wr_n, lcd_rd_n;
    logic [15:0] lcd_db;

    hx8352_bus_writer dut (
        .clk            (clk),
        .rst            (rst),
        .bus_step       (bus_step),
        .command_or_data(command_or_data),
        .data_to_write  (data_to_write),
        .delay_step     (delay_step),
        .delay_value    (delay_value),
        .busy           (busy),
        .bus_done       (bus_done),
        .delay_done     (delay_done),
        .req_dropped    (req_dropped),
        .lcd_rs         (lcd_rs),
        .lcd_wr_n       (lcd_wr_n),
        .lcd_rd_n       (lcd_rd_n),
        .lcd_db         (lcd_db)
    );

    always #5 clk = ~clk;

    typedef enum int {EV_WRITE, EV_BDONE, EV_DDONE} ev_kind_t;
    typedef struct {
        ev_kind_t    kind;
        int          cyc;
        logic        rs;
        logic [15:0] db;
        int          len;
    } ev_t;

    ev_t sb[$];
    int  cyc = 0;
    int  checks = 0;
    int  errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, got, exp);
        end
    endtask

    task automatic push_ev(input ev_kind_t k, input int c, input logic rs, input logic [15:0] db, input int len);
        ev_t e;
        e.kind = k; e.cyc = c; e.rs = rs; e.db = db; e.len = len;
        sb.push_back(e);
    endtask

    task automatic observe(input ev_kind_t k, input int c, input logic rs, input logic [15:0] db,
                           input int len, input bit stable);
        ev_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event got kind=%0d cyc=%0d want none", k, c);
        end else begin
            e = sb.pop_front();
            if (e.kind != k || e.cyc != c || e.rs !== rs || e.db !== db || e.len != len || !stable) begin
                errors++;
                $display("FAIL event got kind=%0d cyc=%0d rs=%0b db=%h low=%0d stable=%0b want kind=%0d cyc=%0d rs=%0b db=%h low=%0d stable=1",
                         k, c, rs, db, len, stable, e.kind, e.cyc, e.rs, e.db, e.len);
            end
        end
    endtask

    // Monitor: reports each completed WR# low window plus done pulses.
    bit          in_low = 0;
    int          fall_cyc, low_len;
    logic        low_rs;
    logic [15:0] low_db;
    bit          low_stable;

    always @(negedge clk) begin
        if (rst) begin
            in_low = 0;
        end else begin
            if (!lcd_wr_n) begin
                if (!in_low) begin
                    in_low = 1; fall_cyc = cyc; low_len = 0;
                    low_rs = lcd_rs; low_db = lcd_db; low_stable = 1;
                end
                low_len++;
                if (lcd_db !== low_db || lcd_rs !== low_rs) low_stable = 0;
            end else if (in_low) begin
                in_low = 0;
                observe(EV_WRITE, fall_cyc, low_rs, low_db, low_len, low_stable);
            end
            if (bus_done)   observe(EV_BDONE, cyc, 1'b0, 16'h0, 0, 1'b1);
            if (delay_done) observe(EV_DDONE, cyc, 1'b0, 16'h0, 0, 1'b1);
        end
    end

    // Called at a negedge; returns at the negedge where bus_done is visible.
    task automatic do_write(input logic rs, input logic [15:0] d, input bit expect_it);
        int c;
        c = cyc;
        bus_step = 1'b1; command_or_data = rs; data_to_write = d;
        if (expect_it) begin
            push_ev(EV_WRITE, c + 2, rs, d, 3);
            push_ev(EV_BDONE, c + 8, 1'b0, 16'h0, 0);
        end
        @(negedge clk);
        bus_step = 1'b0;
        while (cyc < c + 8) @(negedge clk);
    endtask

    task automatic do_delay(input logic [15:0] n);
        int c, done_cyc;
        c = cyc;
        done_cyc = (n == 0) ? c + 2 : c + 1 + int'(n) * 50;
        delay_step = 1'b1; delay_value = n;
        push_ev(EV_DDONE, done_cyc, 1'b0, 16'h0, 0);
        @(negedge clk);
        delay_step = 1'b0;
        while (cyc < done_cyc) @(negedge clk);
    endtask

    initial begin
        int c;
        rst = 1'b1; bus_step = 1'b0; delay_step = 1'b0;
        command_or_data = 1'b0; data_to_write = '0; delay_value = '0;
        repeat (3) @(negedge clk);
        chk("rst_wr_n", lcd_wr_n, 1);
        chk("rst_rd_n", lcd_rd_n, 1);
        chk("rst_rs", lcd_rs, 0);
        chk("rst_db", lcd_db, 0);
        chk("rst_busy", busy, 0);
        chk("rst_flags", {bus_done, delay_done, req_dropped}, 0);
        rst = 1'b0;
        @(negedge clk);

        // Command then data write, second issued on the bus_done cycle.
        do_write(1'b0, 16'h0022, 1'b1);
        do_write(1'b1, 16'hAABB, 1'b1);
        repeat (2) @(negedge clk);
        chk("hold_db", lcd_db, 16'hAABB);
        chk("hold_rs", lcd_rs, 1);
        chk("idle_busy", busy, 0);
        chk("no_drop", req_dropped, 0);

        do_delay(16'd10);
        do_delay(16'd0);
        chk("after_delay_wr_n", lcd_wr_n, 1);

        // Collision, then a write attempt in the middle of the accepted write.
        @(negedge clk);
        c = cyc;
        bus_step = 1'b1; delay_step = 1'b1; command_or_data = 1'b0;
        data_to_write = 16'h2C2C; delay_value = 16'd1;
        push_ev(EV_WRITE, c + 2, 1'b0, 16'h2C2C, 3);
        push_ev(EV_BDONE, c + 8, 1'b0, 16'h0, 0);
        @(negedge clk);
        bus_step = 1'b0; delay_step = 1'b0;
        @(negedge clk);
        chk("collide_drop", req_dropped, 1);
        chk("collide_busy", busy, 1);
        bus_step = 1'b1; command_or_data = 1'b1; data_to_write = 16'hDEAD;
        @(negedge clk);
        bus_step = 1'b0;
        while (cyc < c + 8) @(negedge clk);
        chk("midwrite_db", lcd_db, 16'h2C2C);
        chk("midwrite_drop", req_dropped, 1);

        // Reset while WR# is low.
        repeat (3) @(negedge clk);
        c = cyc;
        bus_step = 1'b1; command_or_data = 1'b1; data_to_write = 16'h5555;
        @(negedge clk);
        bus_step = 1'b0;
        while (cyc < c + 3) @(negedge clk);
        chk("pre_rst_wr_n", lcd_wr_n, 0);
        rst = 1'b1;
        #1;
        chk("mid_rst_wr_n", lcd_wr_n, 1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_drop", req_dropped, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);

        // Init script replay: upstream issues the next step as soon as the previous completes.
        for (int i = 0; i < 50; i++) begin
            if (i % 10 == 9) do_delay(16'(i / 10));
            else do_write((i % 4) != 0, 16'(i * 273 + 7), 1'b1);
        end
        chk("script_drop", req_dropped, 0);

        repeat (20) @(negedge clk);
        while (sb.size() > 0) begin
            ev_t e;
            e = sb.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_event got none want kind=%0d cyc=%0d", e.kind, e.cyc);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
